mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a shared memory port, muxing addresses.
// Define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD cycles under contention.
module mem_port_arbiter #(
    parameter int DW       = 16,
    parameter int MAX_HOLD = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [DW-1:0] addr_a,
    input  logic [DW-1:0] addr_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          sel,
    output logic [DW-1:0] addr_out,
    output logic          busy,
    output logic          timeout
);

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_e;

    state_e     state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic       to_q, to_d;
    logic       hold_hit;

    // With the timeout compiled out this folds to 0 and hold_q becomes dead logic.
    assign hold_hit = TO_EN && (hold_q == HOLD_LIM);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        to_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = last_q ? OWN_A : OWN_B;
                end else if (req_a) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (hold_hit && req_b) begin
                    state_d = OWN_B;
                    to_d    = 1'b1;
                end else if (!req_a) begin
                    state_d = req_b ? OWN_B : IDLE;
                end
            end
            OWN_B: begin
                if (hold_hit && req_a) begin
                    state_d = OWN_A;
                    to_d    = 1'b1;
                end else if (!req_b) begin
                    state_d = req_a ? OWN_A : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE || state_d != state_q) begin
            hold_d = 8'd0;
        end else if (hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
        end

        // last_q: 1 means B was the most recent grantee.
        if (state_d != IDLE && state_d != state_q) begin
            sel_d  = (state_d == OWN_B);
            last_d = (state_d == OWN_B);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            hold_q  <= 8'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end

    assign gnt_a    = (state_q == OWN_A);
    assign gnt_b    = (state_q == OWN_B);
    assign busy     = gnt_a | gnt_b;
    assign sel      = sel_q;
    assign addr_out = sel_q ? addr_b : addr_a;
    assign timeout  = to_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// run, all scored against a cycle-level ownership model.
module tb_mem_port_arbiter;

    localparam int DW   = 16;
    localparam int MAXH = 4;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a = 1'b0;
    logic          req_b = 1'b0;
    logic [DW-1:0] addr_a = '0;
    logic [DW-1:0] addr_b = '0;
    logic          gnt_a, gnt_b, sel, busy, timeout;
    logic [DW-1:0] addr_out;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: owner 0 = none, 1 = A, 2 = B; held = cycles owned so far.
    int own  = 0;
    int last = 2;
    int held = 0;
    bit msel = 1'b0;
    bit mto  = 1'b0;

    mem_port_arbiter #(.DW(DW), .MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .sel     (sel),
        .addr_out(addr_out),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own  = 0;
        last = 2;
        held = 0;
        msel = 1'b0;
        mto  = 1'b0;
    endtask

    task automatic model_step(input bit ra, input bit rb);
        int nxt;
        bit mine, other;
        mto = 1'b0;
        if (own == 0) begin
            if (ra && rb) nxt = (last == 2) ? 1 : 2;
            else if (ra) nxt = 1;
            else if (rb) nxt = 2;
            else nxt = 0;
        end else begin
            mine  = (own == 1) ? ra : rb;
            other = (own == 1) ? rb : ra;
            if (TO_EN && other && held == MAXH) begin
                nxt = 3 - own;
                mto = 1'b1;
            end else if (mine) nxt = own;
            else if (other) nxt = 3 - own;
            else nxt = 0;
        end
        if (nxt != 0 && nxt == own) held++;
        else held = (nxt == 0) ? 0 : 1;
        if (nxt != 0) begin
            last = nxt;
            msel = (nxt == 2);
        end
        own = nxt;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gnt_a"}, 32'(gnt_a), 32'(own == 1));
        chk({tag, ".gnt_b"}, 32'(gnt_b), 32'(own == 2));
        chk({tag, ".busy"}, 32'(busy), 32'(own != 0));
        chk({tag, ".sel"}, 32'(sel), 32'(msel));
        chk({tag, ".addr"}, 32'(addr_out), 32'(msel ? addr_b : addr_a));
        chk({tag, ".timeout"}, 32'(timeout), 32'(mto));
    endtask

    task automatic step(input bit ra, input bit rb, input string tag);
        @(negedge clk);
        req_a  = ra;
        req_b  = rb;
        addr_a = DW'($urandom);
        addr_b = DW'($urandom);
        @(posedge clk);
        model_step(ra, rb);
        #1;
        check_all(tag);
    endtask

    initial begin
        int seq[$];
        int prev;
        bit ra, rb;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous first requests: A wins the first tie
        step(1, 1, "tie");
        chk("tie.gnt_a", 32'(gnt_a), 32'd1);
        chk("tie.sel", 32'(sel), 32'd0);
        chk("tie.addr", 32'(addr_out), 32'(addr_a));

        // A holds 3 cycles, then hands straight to B
        step(1, 0, "holdA");
        step(1, 0, "holdA");
        step(0, 1, "handover");
        chk("handover.gnt_b", 32'(gnt_b), 32'd1);
        chk("handover.sel", 32'(sel), 32'd1);
        chk("handover.busy", 32'(busy), 32'd1);
        step(0, 0, "release");
        chk("release.busy", 32'(busy), 32'd0);

        // Round-robin alternation, each owner releasing after 2 cycles
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            ra = !(own == 1 && held >= 2);
            rb = !(own == 2 && held >= 2);
            step(ra, rb, "alt");
            if (own != 0 && own != prev) seq.push_back(own);
            prev = own;
        end
        chk("alt.count", 32'(seq.size() >= 4), 32'd1);
        for (int i = 0; i < seq.size(); i++)
            chk("alt.order", 32'(seq[i]), 32'((i % 2 == 0) ? 1 : 2));

        // Request pulse entirely between edges in IDLE gets no grant
        step(0, 0, "idle");
        step(0, 0, "idle");
        @(negedge clk);
        req_a = 1'b1;
        #2 req_a = 1'b0;
        @(posedge clk);
        model_step(0, 0);
        #1;
        chk("glitch.gnt_a", 32'(gnt_a), 32'd0);
        check_all("glitch");

        // A holds forever while B requests
        step(1, 0, "toA");
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < MAXH - 1; i++) begin
            step(1, 1, "to.hold");
            chk("to.hold.gnt_a", 32'(gnt_a), 32'd1);
        end
        step(1, 1, "to.revoke");
        chk("to.revoke.timeout", 32'(timeout), 32'd1);
        chk("to.revoke.gnt_b", 32'(gnt_b), 32'd1);
        step(1, 1, "to.after");
        chk("to.after.timeout", 32'(timeout), 32'd0);
`else
        for (int i = 0; i < 50; i++) begin
            step(1, 1, "notimeout");
            chk("notimeout.gnt_a", 32'(gnt_a), 32'd1);
            chk("notimeout.timeout", 32'(timeout), 32'd0);
        end
`endif

        // Asynchronous reset in the middle of an OWN_B grant
        step(0, 0, "pre_rst");
        step(0, 1, "ownB");
        chk("ownB.gnt_b", 32'(gnt_b), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.gnt_b", 32'(gnt_b), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.sel", 32'(sel), 32'd0);
        @(negedge clk);
        req_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, "post_rst");
        chk("post_rst.gnt_a", 32'(gnt_a), 32'd1);

        // Random run
        for (int i = 0; i < 2000; i++) begin
            ra = ($urandom_range(3, 0) != 0);
            rb = ($urandom_range(3, 0) != 0);
            step(ra, rb, "rand");
            chk("rand.onehot", 32'({gnt_a, gnt_b} != 2'b11), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
